out_wr_ctrl: RTL and testbench
==============================

// Module: out_wr_ctrl
// PURPOSE
// - Capture stage between systolic array and output memory banks: takes skewed 16-bit column results, drives per-bank write port.
// - Column i's results arrive i cycles after column 0's.
// - Generates per-bank wr_en/wr_addr/wr_data, de-skewing so row r of every column lands at base_addr+r in its own bank.
// - One start/done job per matrix tile.
// PARAMETERS
// - WIDTH_HEIGHT  4   array columns = output banks
// - DATA_W        16  result width per column
// - ADDR_W        8   bank address width
// - START_LAT     2   cycles from start acceptance to column-0 row-0 on sys_data (0..255)
// PORTS
// - clk        in   1                    clock, rising edge
// - reset_n    in   1                    async active-low reset
// - start      in   1                    job request; accepted only when busy=0
// - base_addr  in   ADDR_W               first write address, sampled on accept
// - num_rows   in   ADDR_W               rows per column, sampled on accept (0 allowed)
// - sys_data   in   WIDTH_HEIGHT*DATA_W  systolic column outputs, column i at [i*DATA_W +: DATA_W]
// - wr_en      out  WIDTH_HEIGHT         per-bank write enable
// - wr_addr    out  WIDTH_HEIGHT*ADDR_W  per-bank write address, bank i at [i*ADDR_W +: ADDR_W]
// - wr_data    out  WIDTH_HEIGHT*DATA_W  per-bank write data
// - busy       out  1                    job in progress
// - done       out  1                    one-cycle completion pulse
// BEHAVIOUR
// - Reset: all outputs 0; FSM IDLE; counters 0. Async assert, sync release.
// - FSM: IDLE -> WAIT -> STREAM -> DONE -> IDLE.
//   - IDLE: start=1 at edge k latches base_addr/num_rows; busy=1 from cycle after k.
//     - START_LAT=0: go straight to STREAM. Else WAIT.
//   - WAIT: count START_LAT-1 further edges, then STREAM.
//   - STREAM: stream counter c = 0 .. num_rows+WIDTH_HEIGHT-2, one per edge.
//     - Column i is sampled at edge c when i <= c < i+num_rows.
//     - Column-0 row-0 sample edge = k+START_LAT+1.
//   - DONE: one cycle, done=1, busy=0; IDLE next.
// - num_rows=0: skip STREAM; DONE immediately after WAIT (or the cycle after accept if START_LAT=0); no wr_en ever asserted.
// - Write output, 1-cycle latency (all registered):
//   - Cycle after a sample edge for column i: wr_en[i]=1, wr_addr[i]=base_addr+(c-i) mod 2^ADDR_W, wr_data[i]=sampled sys_data slice.
//   - Non-sampled columns: wr_en[i]=0; wr_addr/wr_data hold last value.
// - Address wrap: modulo 2^ADDR_W; no error flag.
// - Last write cycle (bank WIDTH_HEIGHT-1, row num_rows-1) is followed directly by the DONE cycle.
// - start while busy=1 (WAIT/STREAM/DONE): ignored, not queued.
//   - start in the IDLE cycle after DONE is accepted (back-to-back jobs, one idle gap).
// - Reset mid-job: wr_en drops asynchronously; no further writes; job lost; done not pulsed.
// - Counter widths: c needs ADDR_W+1 bits (max num_rows+WIDTH_HEIGHT-2); wait counter 8 bits.
// STRUCTURE
// - Shared include tpu_params.vh: FSM state encodings (IDLE/WAIT/STREAM/DONE), DATA_W/ADDR_W defaults.
// - Sub-module out_wr_lane: one per column via generate loop.
//   - Inputs: c, lane index, num_rows, base_addr.
//   - Owns the wr_en/wr_addr/wr_data registers for its bank.
// - Top holds the FSM and the shared c/wait counters.
// TESTING (WIDTH_HEIGHT=4, START_LAT=2 unless noted)
// - Basic: start at edge k, base=0x10, rows=3.
//   -> bank0 writes 0x10..0x12 in cycles k+4..k+6; bank3 in k+7..k+9; done in k+10.
//   -> wr_data equals sys_data slice from the preceding edge.
// - Wrap: base=0xFE, rows=4 -> every bank writes 0xFE,0xFF,0x00,0x01 in order.
// - Zero rows: rows=0 -> no wr_en asserted; done 3 cycles after accept (k+3).
// - Busy start: start pulses during STREAM -> ignored, exactly one done.
//   - Start in the IDLE cycle after done -> second job accepted with new base.
// - Reset mid-STREAM: reset_n low after bank0's 2nd write -> outputs 0 immediately.
//   - After release: idle, no writes until next start.
// - START_LAT=0, base=0, rows=1 -> bank i writes addr 0 in cycle k+2+i; done k+6.

Source files
------------

// File: rtl/out_wr_ctrl_pkg.sv
// Shared types and default parameters for the output-memory write controller.
// Both the top FSM and the per-bank lanes import this package.
package out_wr_ctrl_pkg;

  localparam int DEF_WIDTH_HEIGHT = 4;
  localparam int DEF_DATA_W       = 16;
  localparam int DEF_ADDR_W       = 8;
  localparam int DEF_START_LAT    = 2;
  localparam int WAIT_W           = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/out_wr_lane.sv
// One bank's write port: samples its skewed column during its row window and
// drives registered wr_en/wr_addr/wr_data one cycle later.
module out_wr_lane
  import out_wr_ctrl_pkg::*;
#(
  parameter int LANE   = 0,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stream,
  input  logic [ADDR_W:0]   c,
  input  logic [ADDR_W-1:0] num_rows,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DATA_W-1:0] col_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam logic [ADDR_W:0] LANE_C = (ADDR_W+1)'(LANE);

  logic              sample;
  logic [ADDR_W-1:0] row_lo;

  // Column LANE lags column 0 by LANE cycles, so its rows occupy c in [LANE, LANE+num_rows).
  assign sample = stream && (c >= LANE_C) && (c < LANE_C + {1'b0, num_rows});
  assign row_lo = c[ADDR_W-1:0] - LANE_C[ADDR_W-1:0];

  // NOTE: wr_addr/wr_data are ordinary registers (not a memory array), so they take the async reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      // NOTE: non-blocking assignments for every registered signal, so all lanes update in parallel.
      wr_en <= sample;
      if (sample) begin
        wr_addr <= base_addr + row_lo;
        wr_data <= col_data;
      end
    end
  end

endmodule

// File: rtl/out_wr_ctrl.sv
// Capture stage between the systolic array and the output banks: job FSM and
// shared counters; per-bank de-skewed writes are done by out_wr_lane instances.
module out_wr_ctrl
  import out_wr_ctrl_pkg::*;
#(
  parameter int WIDTH_HEIGHT = DEF_WIDTH_HEIGHT,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int START_LAT    = DEF_START_LAT
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [ADDR_W-1:0]              base_addr,
  input  logic [ADDR_W-1:0]              num_rows,
  input  logic [WIDTH_HEIGHT*DATA_W-1:0] sys_data,
  output logic [WIDTH_HEIGHT-1:0]        wr_en,
  output logic [WIDTH_HEIGHT*ADDR_W-1:0] wr_addr,
  output logic [WIDTH_HEIGHT*DATA_W-1:0] wr_data,
  output logic                           busy,
  output logic                           done
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = (START_LAT == 0) ? '0 : WAIT_W'(START_LAT - 1);
  // One drain step past the last sample so DONE follows the final registered write.
  localparam logic [ADDR_W:0]   C_TAIL    = (ADDR_W+1)'(WIDTH_HEIGHT - 1);

  state_e            state, state_nx;
  logic              accept;
  logic [ADDR_W:0]   c;
  logic [ADDR_W:0]   c_end;
  logic [WAIT_W-1:0] wait_cnt;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] rows_q;

  assign c_end = {1'b0, rows_q} + C_TAIL;

  // NOTE: defaults first so every path assigns each output of this block; no latches.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (START_LAT == 0) state_nx = (num_rows == '0) ? ST_DONE : ST_STREAM;
          else                state_nx = ST_WAIT;
        end
      end
      ST_WAIT:   if (wait_cnt == WAIT_LAST) state_nx = (rows_q == '0) ? ST_DONE : ST_STREAM;
      ST_STREAM: if (c == c_end) state_nx = ST_DONE;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      c        <= '0;
      wait_cnt <= '0;
      base_q   <= '0;
      rows_q   <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= (state == ST_WAIT)   ? wait_cnt + WAIT_W'(1) : '0;
      c        <= (state == ST_STREAM) ? c + (ADDR_W+1)'(1)    : '0;
      if (accept) begin
        base_q <= base_addr;
        rows_q <= num_rows;
      end
    end
  end

  assign busy = (state == ST_WAIT) || (state == ST_STREAM);
  assign done = (state == ST_DONE);

  for (genvar i = 0; i < WIDTH_HEIGHT; i++) begin : g_lane
    out_wr_lane #(
      .LANE   (i),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_lane (
      .clk       (clk),
      .reset_n   (reset_n),
      .stream    (state == ST_STREAM),
      .c         (c),
      .num_rows  (rows_q),
      .base_addr (base_q),
      .col_data  (sys_data[i*DATA_W +: DATA_W]),
      .wr_en     (wr_en[i]),
      .wr_addr   (wr_addr[i*ADDR_W +: ADDR_W]),
      .wr_data   (wr_data[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_out_wr_ctrl.sv
// Bench for out_wr_ctrl: a per-edge schedule model of expected writes/busy/done
// checked every cycle, plus directed scenarios with literal expectations.
module tb_out_wr_ctrl;

  localparam int WH   = 4;
  localparam int DW   = 16;
  localparam int AW   = 8;
  localparam int LAT  = 2;
  localparam int MAXE = 2048;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic [AW-1:0]   base_addr = '0;
  logic [AW-1:0]   num_rows = '0;
  logic [WH*DW-1:0] sys_data = '0;
  logic [WH-1:0]   wr_en;
  logic [WH*AW-1:0] wr_addr;
  logic [WH*DW-1:0] wr_data;
  logic            busy, done;

  logic            start0 = 1'b0;
  logic [AW-1:0]   base0 = '0;
  logic [AW-1:0]   rows0 = '0;
  logic [WH-1:0]   wr_en0;
  logic [WH*AW-1:0] wr_addr0;
  logic [WH*DW-1:0] wr_data0;
  logic            busy0, done0;

  out_wr_ctrl #(.WIDTH_HEIGHT(WH), .DATA_W(DW), .ADDR_W(AW), .START_LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .sys_data(sys_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done));

  out_wr_ctrl #(.WIDTH_HEIGHT(WH), .DATA_W(DW), .ADDR_W(AW), .START_LAT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .base_addr(base0), .num_rows(rows0),
    .sys_data(sys_data), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .busy(busy0), .done(done0));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got 0x%0h, expected 0x%0h", name, edge_n, act, exp);
    end
  endtask

  // Column i's value presented at edge e.
  function automatic logic [DW-1:0] pat(input int e, input int i);
    return DW'((i << 12) | (e & 12'hFFF));
  endfunction

  // Expected outputs as observed just after edge e.
  bit [WH-1:0] exp_en   [MAXE];
  bit [AW-1:0] exp_addr [MAXE][WH];
  bit [DW-1:0] exp_data [MAXE][WH];
  bit          exp_busy [MAXE];
  bit          exp_done [MAXE];
  bit          job_live = 1'b0;
  int          done_e   = 0;

  always @(posedge clk) begin
    edge_n++;
    if (!reset_n) begin
      job_live = 1'b0;
      for (int e = edge_n; e < MAXE; e++) begin
        exp_en[e] = '0; exp_busy[e] = 1'b0; exp_done[e] = 1'b0;
      end
    end else if (start && !(job_live && edge_n <= done_e + 1)) begin
      int k, rows;
      k        = edge_n;
      rows     = int'(num_rows);
      job_live = 1'b1;
      done_e   = (rows == 0) ? k + LAT : k + LAT + rows + WH;
      for (int e = k; e < done_e; e++) exp_busy[e] = 1'b1;
      exp_done[done_e] = 1'b1;
      for (int i = 0; i < WH; i++) begin
        for (int r = 0; r < rows; r++) begin
          int e;
          e = k + LAT + 1 + i + r;
          exp_en[e][i]   = 1'b1;
          exp_addr[e][i] = AW'(int'(base_addr) + r);
          exp_data[e][i] = pat(e, i);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < WH; i++) sys_data[i*DW +: DW] = pat(edge_n + 1, i);
  end

  bit [AW-1:0] hold_addr [WH];
  bit [DW-1:0] hold_data [WH];

  always @(negedge clk) begin
    if (edge_n > 0) begin
      if (!reset_n) begin
        for (int i = 0; i < WH; i++) begin hold_addr[i] = '0; hold_data[i] = '0; end
      end
      check("model_busy", 32'(busy), 32'(exp_busy[edge_n]));
      check("model_done", 32'(done), 32'(exp_done[edge_n]));
      for (int i = 0; i < WH; i++) begin
        if (exp_en[edge_n][i]) begin
          hold_addr[i] = exp_addr[edge_n][i];
          hold_data[i] = exp_data[edge_n][i];
        end
        check($sformatf("model_wr_en[%0d]", i), 32'(wr_en[i]), 32'(exp_en[edge_n][i]));
        check($sformatf("model_wr_addr[%0d]", i), 32'(wr_addr[i*AW +: AW]), 32'(hold_addr[i]));
        check($sformatf("model_wr_data[%0d]", i), 32'(wr_data[i*DW +: DW]), 32'(hold_data[i]));
      end
    end
  end

  // Called at a negedge; returns the edge at which start was accepted-or-offered.
  task automatic go(input logic [AW-1:0] b, input logic [AW-1:0] r, output int k);
    start = 1'b1; base_addr = b; num_rows = r;
    @(negedge clk);
    k = edge_n;
    start = 1'b0;
  endtask

  task automatic wait_edge(input int target);
    int guard;
    guard = 0;
    while (edge_n < target && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("wait_edge", 32'(edge_n), 32'(target));
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((busy || done) && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    check("wait_idle_timeout", 32'(busy || done), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    int k, k2;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_wr_en", 32'(wr_en), 32'd0);
    check("reset_wr_addr", wr_addr, 32'd0);
    #2 reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic job: base 0x10, 3 rows.
    go(8'h10, 8'd3, k);
    check("basic_busy_after_accept", 32'(busy), 32'd1);
    wait_edge(k + 3);
    check("basic_b0_first_en", 32'(wr_en), 32'h1);
    check("basic_b0_first_addr", 32'(wr_addr[7:0]), 32'h10);
    check("basic_b0_first_data", 32'(wr_data[15:0]), 32'(pat(k + 3, 0)));
    wait_edge(k + 8);
    check("basic_b3_last_en", 32'(wr_en), 32'h8);
    check("basic_b3_last_addr", 32'(wr_addr[31:24]), 32'h12);
    wait_edge(k + 9);
    check("basic_done", 32'(done), 32'd1);
    check("basic_done_busy", 32'(busy), 32'd0);
    check("basic_done_no_wr", 32'(wr_en), 32'd0);
    wait_idle();

    // Address wrap: base 0xFE, 4 rows.
    go(8'hFE, 8'd4, k);
    wait_edge(k + 7);
    check("wrap_en", 32'(wr_en), 32'hE);
    check("wrap_b1_addr", 32'(wr_addr[15:8]), 32'h01);
    check("wrap_b2_addr", 32'(wr_addr[23:16]), 32'h00);
    check("wrap_b3_addr", 32'(wr_addr[31:24]), 32'hFF);
    wait_idle();

    // Zero rows.
    go(8'h77, 8'd0, k);
    wait_edge(k + 2);
    check("zero_done", 32'(done), 32'd1);
    check("zero_no_wr", 32'(wr_en), 32'd0);
    wait_idle();

    // Start while busy is ignored; start in DONE ignored; start in following IDLE accepted.
    go(8'h20, 8'd3, k);
    wait_edge(k + 4);
    start = 1'b1; base_addr = 8'h80; num_rows = 8'd1;
    @(negedge clk); start = 1'b0;
    wait_edge(k + 6);
    start = 1'b1; base_addr = 8'h81;
    @(negedge clk); start = 1'b0;
    wait_edge(k + 9);
    check("busy_start_done", 32'(done), 32'd1);
    start = 1'b1; base_addr = 8'h99; num_rows = 8'd5;
    @(negedge clk);
    check("idle_after_done", 32'(busy || done), 32'd0);
    start = 1'b1; base_addr = 8'h40; num_rows = 8'd2;
    @(negedge clk);
    k2 = edge_n;
    start = 1'b0;
    check("b2b_accept_edge", 32'(k2), 32'(k + 11));
    wait_edge(k2 + 3);
    check("b2b_first_en", 32'(wr_en), 32'h1);
    check("b2b_first_addr", 32'(wr_addr[7:0]), 32'h40);
    wait_idle();

    // Reset in the middle of streaming.
    go(8'h30, 8'd4, k);
    wait_edge(k + 4);
    check("rst_b0_second_addr", 32'(wr_addr[7:0]), 32'h31);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_wr_en", 32'(wr_en), 32'd0);
    check("rst_async_busy", 32'(busy), 32'd0);
    check("rst_async_wr_addr", wr_addr, 32'd0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_after_release_busy", 32'(busy), 32'd0);
    go(8'h50, 8'd2, k);
    wait_idle();

    // START_LAT=0 instance: base 0, 1 row.
    start0 = 1'b1; base0 = 8'h00; rows0 = 8'd1;
    @(negedge clk);
    k = edge_n;
    start0 = 1'b0;
    check("lat0_busy_accept", 32'(busy0), 32'd1);
    check("lat0_no_wr_accept", 32'(wr_en0), 32'd0);
    for (int d = 1; d <= 5; d++) begin
      @(negedge clk);
      check($sformatf("lat0_en_d%0d", d), 32'(wr_en0), (d <= 4) ? 32'(1 << (d - 1)) : 32'd0);
      check($sformatf("lat0_done_d%0d", d), 32'(done0), 32'(d == 5));
      check($sformatf("lat0_busy_d%0d", d), 32'(busy0), 32'(d < 5));
      if (d <= 4) begin
        check($sformatf("lat0_addr_d%0d", d), 32'(wr_addr0[(d-1)*AW +: AW]), 32'd0);
        check($sformatf("lat0_data_d%0d", d), 32'(wr_data0[(d-1)*DW +: DW]), 32'(pat(k + d, d - 1)));
      end
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
